// File: rtl/fft_r22sdf_reorder.sv
// Ping-pong reorder buffer for R2^2 SDF FFT output.
// Bit-reversed samples in, gap-free natural-order (or pass-through) frames out.
module fft_r22sdf_reorder #(
    parameter int N_LOG2     = 10,
    parameter int DATA_WIDTH = 25
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    input  logic                  sof_i,
    input  logic                  nat_order_i,
    input  logic [DATA_WIDTH-1:0] data_re_i,
    input  logic [DATA_WIDTH-1:0] data_im_i,
    output logic                  valid_o,
    output logic                  last_o,
    output logic [N_LOG2-1:0]     bin_o,
    output logic [DATA_WIDTH-1:0] data_re_o,
    output logic [DATA_WIDTH-1:0] data_im_o,
    output logic                  frame_drop_o
);

    localparam int N = 1 << N_LOG2;
    localparam logic [N_LOG2-1:0] CTR_MAX = '1;

    typedef enum logic {
        ST_IDLE,
        ST_READ
    } state_t;

    function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] x);
        logic [N_LOG2-1:0] r;
        r = '0;
        for (int i = 0; i < N_LOG2; i++) begin
            r[i] = x[N_LOG2-1-i];
        end
        return r;
    endfunction

    // Bank select is the MSB of the RAM address
    logic [2*DATA_WIDTH-1:0] mem [2*N];
    logic [2*DATA_WIDTH-1:0] rd_data_q;

    logic [N_LOG2-1:0] wr_ctr_q, wr_ctr_d;
    logic              wr_bank_q, wr_bank_d;
    logic [1:0]        full_q, full_d;
    logic [1:0]        nat_q, nat_d;
    logic              drop_q, drop_d;
    logic [N_LOG2-1:0] wr_idx;
    logic              wr_nat;
    logic [N_LOG2:0]   wr_addr;
    logic [1:0]        wr_fill;

    state_t            state_q, state_d;
    logic              rd_bank_q, rd_bank_d;
    logic [N_LOG2-1:0] rd_ctr_q, rd_ctr_d;
    logic [1:0]        rd_free;
    logic              rd_en;
    logic [N_LOG2:0]   rd_addr;

    logic              s1_valid_q, s1_valid_d;
    logic              s1_last_q, s1_last_d;
    logic [N_LOG2-1:0] s1_bin_q, s1_bin_d;

    logic                  valid_q, valid_d;
    logic                  last_q, last_d;
    logic [N_LOG2-1:0]     bin_q, bin_d;
    logic [DATA_WIDTH-1:0] re_q, re_d;
    logic [DATA_WIDTH-1:0] im_q, im_d;

    // A sof restarts the frame in place; the partial data is simply overwritten
    always_comb begin
        wr_idx    = sof_i ? '0 : wr_ctr_q;
        wr_nat    = (wr_idx == '0) ? nat_order_i : nat_q[wr_bank_q];
        wr_addr   = {wr_bank_q, (wr_nat ? bitrev(wr_idx) : wr_idx)};
        wr_ctr_d  = wr_ctr_q;
        wr_bank_d = wr_bank_q;
        nat_d     = nat_q;
        wr_fill   = '0;
        drop_d    = 1'b0;
        if (valid_i) begin
            drop_d = sof_i && (wr_ctr_q != '0);
            if (wr_idx == '0) begin
                nat_d[wr_bank_q] = nat_order_i;
            end
            if (wr_idx == CTR_MAX) begin
                wr_ctr_d           = '0;
                wr_bank_d          = ~wr_bank_q;
                wr_fill[wr_bank_q] = 1'b1;
            end else begin
                wr_ctr_d = wr_idx + N_LOG2'(1);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rd_bank_d  = rd_bank_q;
        rd_ctr_d   = rd_ctr_q;
        rd_free    = '0;
        rd_en      = 1'b0;
        s1_valid_d = 1'b0;
        s1_last_d  = 1'b0;
        s1_bin_d   = s1_bin_q;
        unique case (state_q)
            ST_IDLE: begin
                if (|full_q) begin
                    state_d   = ST_READ;
                    rd_ctr_d  = '0;
                    // With both full, the older frame sits in the bank about to be rewritten
                    rd_bank_d = (&full_q) ? wr_bank_q : full_q[1];
                end
            end
            ST_READ: begin
                rd_en      = 1'b1;
                s1_valid_d = 1'b1;
                s1_last_d  = (rd_ctr_q == CTR_MAX);
                s1_bin_d   = nat_q[rd_bank_q] ? rd_ctr_q : bitrev(rd_ctr_q);
                if (rd_ctr_q == CTR_MAX) begin
                    rd_free[rd_bank_q] = 1'b1;
                    if (full_q[~rd_bank_q]) begin
                        rd_bank_d = ~rd_bank_q;
                        rd_ctr_d  = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    rd_ctr_d = rd_ctr_q + N_LOG2'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign rd_addr = {rd_bank_q, rd_ctr_q};

    always_comb begin
        full_d  = (full_q & ~rd_free) | wr_fill;
        valid_d = s1_valid_q;
        last_d  = s1_valid_q & s1_last_q;
        bin_d   = s1_valid_q ? s1_bin_q : bin_q;
        re_d    = s1_valid_q ? rd_data_q[2*DATA_WIDTH-1:DATA_WIDTH] : re_q;
        im_d    = s1_valid_q ? rd_data_q[DATA_WIDTH-1:0] : im_q;
    end

    always_ff @(posedge clk_i) begin
        if (valid_i) begin
            mem[wr_addr] <= {data_re_i, data_im_i};
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ctr_q   <= '0;
            wr_bank_q  <= 1'b0;
            full_q     <= '0;
            nat_q      <= '0;
            drop_q     <= 1'b0;
            state_q    <= ST_IDLE;
            rd_bank_q  <= 1'b0;
            rd_ctr_q   <= '0;
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_bin_q   <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            bin_q      <= '0;
            re_q       <= '0;
            im_q       <= '0;
        end else begin
            wr_ctr_q   <= wr_ctr_d;
            wr_bank_q  <= wr_bank_d;
            full_q     <= full_d;
            nat_q      <= nat_d;
            drop_q     <= drop_d;
            state_q    <= state_d;
            rd_bank_q  <= rd_bank_d;
            rd_ctr_q   <= rd_ctr_d;
            s1_valid_q <= s1_valid_d;
            s1_last_q  <= s1_last_d;
            s1_bin_q   <= s1_bin_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            bin_q      <= bin_d;
            re_q       <= re_d;
            im_q       <= im_d;
        end
    end

    assign valid_o      = valid_q;
    assign last_o       = last_q;
    assign bin_o        = bin_q;
    assign data_re_o    = re_q;
    assign data_im_o    = im_q;
    assign frame_drop_o = drop_q;

endmodule
